// File: rtl/note_sequencer_pkg.sv
// Shared types, widths and note-word field helpers for the note sequencer.
package note_pkg;

   localparam int NUM_NOTES = 32;
   localparam int WORD_W    = 16;
   localparam int NOTE_W    = 8;
   localparam int DUR_W     = 8;
   localparam int IDX_W     = 5;
   localparam int TICK_W    = 24;

   localparam logic [IDX_W-1:0] LAST_IDX = 5'd31;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_PLAY = 2'd2,
      ST_DONE = 2'd3
   } seq_state_t;

   function automatic logic [NOTE_W-1:0] note_field(input logic [WORD_W-1:0] word);
      return word[15:8];
   endfunction

   function automatic logic [DUR_W-1:0] dur_field(input logic [WORD_W-1:0] word);
      return word[7:0];
   endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Bundle of note-table, control and playback status signals of the sequencer.
interface note_sequencer_if;
   import note_pkg::*;

   logic [WORD_W-1:0] notes [0:NUM_NOTES-1];
   logic              notes_valid;
   logic              start;
   logic              pause;
   logic [NOTE_W-1:0] note_num;
   logic              note_on;
   logic              note_strobe;
   logic [IDX_W-1:0]  note_index;
   logic              busy;
   logic              song_done;

   modport master (
      output notes, notes_valid, start, pause,
      input  note_num, note_on, note_strobe, note_index, busy, song_done
   );

   modport slave (
      input  notes, notes_valid, start, pause,
      output note_num, note_on, note_strobe, note_index, busy, song_done
   );

endinterface

// File: rtl/note_sequencer_tick_prescaler.sv
// Duration prescaler: pulses tick on the last cycle of every TICK_CYCLES
// enabled cycles; holds its count while enable is low.
module tick_prescaler
   import note_pkg::*;
#(
   parameter int TICK_CYCLES = 1_500_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

   logic [TICK_W-1:0] count_r;

   assign tick = enable && (count_r == TICK_LAST);

   // Cycle counter within the current tick
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_r <= {TICK_W{1'b0}};
      end else if (clear) begin
         count_r <= {TICK_W{1'b0}};
      end else if (enable) begin
         count_r <= tick ? {TICK_W{1'b0}} : count_r + 24'd1;
      end
   end

endmodule

// File: rtl/note_sequencer.sv
// Note sequencer: walks a 32-entry note table from index 0, sounding each note
// for its duration in prescaled ticks until an end marker or the last entry.
module note_sequencer
   import note_pkg::*;
#(
   parameter int TICK_CYCLES = 1_500_000
) (
   input  logic           clk,
   input  logic           reset,
   note_sequencer_if.slave bus
);

   seq_state_t        state_r;
   logic              start_r;
   logic              run_r;
   logic [DUR_W-1:0]  remaining_r;
   logic [IDX_W-1:0]  index_r;
   logic [NOTE_W-1:0] note_num_r;
   logic              note_on_r;
   logic              strobe_r;
   logic              busy_r;
   logic              done_r;

   logic [WORD_W-1:0] word_s;
   logic              clear_s;
   logic              enable_s;
   logic              tick_s;

   // Current table word and prescaler controls; run_r is the pause state as
   // seen by note_on, so counted cycles and sounding cycles always agree.
   always_comb begin
      word_s   = bus.notes[index_r];
      clear_s  = (state_r != ST_PLAY);
      enable_s = (state_r == ST_PLAY) && run_r;
   end

   tick_prescaler #(
      .TICK_CYCLES (TICK_CYCLES)
   ) u_tick (
      .clk    (clk),
      .reset  (reset),
      .clear  (clear_s),
      .enable (enable_s),
      .tick   (tick_s)
   );

   // Sequencer FSM with all outputs registered alongside the state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= ST_IDLE;
         start_r     <= 1'b0;
         run_r       <= 1'b0;
         remaining_r <= {DUR_W{1'b0}};
         index_r     <= {IDX_W{1'b0}};
         note_num_r  <= {NOTE_W{1'b0}};
         note_on_r   <= 1'b0;
         strobe_r    <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         start_r  <= bus.start;
         strobe_r <= 1'b0;
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (start_r && bus.notes_valid) begin
                  index_r <= {IDX_W{1'b0}};
                  state_r <= ST_LOAD;
                  busy_r  <= 1'b1;
                  done_r  <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (!bus.notes_valid) begin
                  state_r   <= ST_IDLE;
                  busy_r    <= 1'b0;
                  note_on_r <= 1'b0;
                  run_r     <= 1'b0;
               end else if (dur_field(word_s) == 8'd0) begin
                  state_r   <= ST_DONE;
                  busy_r    <= 1'b0;
                  done_r    <= 1'b1;
                  note_on_r <= 1'b0;
                  run_r     <= 1'b0;
               end else begin
                  state_r     <= ST_PLAY;
                  note_num_r  <= note_field(word_s);
                  remaining_r <= dur_field(word_s);
                  strobe_r    <= 1'b1;
                  run_r       <= !bus.pause;
                  note_on_r   <= (note_field(word_s) != 8'd0) && !bus.pause;
               end
            end
            ST_PLAY: begin
               if (!bus.notes_valid) begin
                  state_r   <= ST_IDLE;
                  busy_r    <= 1'b0;
                  note_on_r <= 1'b0;
                  run_r     <= 1'b0;
               end else if (tick_s && (remaining_r == 8'd1)) begin
                  remaining_r <= {DUR_W{1'b0}};
                  note_on_r   <= 1'b0;
                  run_r       <= 1'b0;
                  if (index_r == LAST_IDX) begin
                     state_r <= ST_DONE;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                  end else begin
                     index_r <= index_r + 5'd1;
                     state_r <= ST_LOAD;
                  end
               end else begin
                  if (tick_s) begin
                     remaining_r <= remaining_r - 8'd1;
                  end
                  run_r     <= !bus.pause;
                  note_on_r <= (note_num_r != 8'd0) && !bus.pause;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               busy_r    <= 1'b0;
               done_r    <= 1'b0;
               note_on_r <= 1'b0;
               run_r     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.note_num    = note_num_r;
   assign bus.note_on     = note_on_r;
   assign bus.note_strobe = strobe_r;
   assign bus.note_index  = index_r;
   assign bus.busy        = busy_r;
   assign bus.song_done   = done_r;

endmodule

// File: tb/tb_note_sequencer.sv
// Randomized self-checking bench for note_sequencer against a schedule model
// derived from the note table with plain arithmetic.
module tb_note_sequencer;

   localparam int T = 4;

   logic clk;
   logic reset;

   note_sequencer_if bus_if ();

   note_sequencer #(
      .TICK_CYCLES (T)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [15:0] tbl [32];
   int exp_cyc[$], exp_num[$], exp_idx[$], exp_on[$];
   int obs_cyc[$], obs_num[$], obs_idx[$], obs_on[$];
   int exp_done, done_cyc;
   bit timeout, dbl_strobe, on_in_pause, on_orphan;
   int pf, pl;

   task automatic load_table();
      for (int i = 0; i < 32; i++) bus_if.notes[i] = tbl[i];
   endtask

   task automatic rand_table(input int len);
      logic [7:0] n;
      logic [7:0] d;
      for (int i = 0; i < 32; i++) tbl[i] = 16'h0000;
      for (int i = 0; i < len; i++) begin
         d = 8'($urandom_range(1, 3));
         n = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
         tbl[i] = {n, d};
      end
      if (len < 32) tbl[len] = {8'($urandom_range(0, 255)), 8'h00};
   endtask

   // Expected strobe cycles (counted from the start pulse), words and sounding time
   task automatic build_expected();
      int load_c, d, n;
      exp_cyc.delete(); exp_num.delete(); exp_idx.delete(); exp_on.delete();
      exp_done = -1;
      load_c = 1;
      for (int i = 0; i < 32; i++) begin
         d = int'(tbl[i][7:0]);
         n = int'(tbl[i][15:8]);
         if (d == 0) begin
            exp_done = load_c + 1;
            break;
         end
         exp_cyc.push_back(load_c + 1);
         exp_num.push_back(n);
         exp_idx.push_back(i);
         exp_on.push_back((n != 0) ? d * T : 0);
         if (i == 31) exp_done = load_c + 1 + d * T;
         else load_c = load_c + 1 + d * T;
      end
   endtask

   // Pulse start, then record strobes, sounding time and completion cycle
   task automatic run_song(input int budget, input int pmode, input int poke);
      bit prev_p, prev_s;
      obs_cyc.delete(); obs_num.delete(); obs_idx.delete(); obs_on.delete();
      done_cyc = -1; dbl_strobe = 0; on_in_pause = 0; on_orphan = 0;
      @(negedge clk); bus_if.start = 1'b1;
      @(negedge clk); bus_if.start = 1'b0;
      prev_p = 0; prev_s = 0;
      for (int cyc = 1; cyc <= budget; cyc++) begin
         @(negedge clk);
         if (bus_if.note_strobe) begin
            if (prev_s) dbl_strobe = 1;
            obs_cyc.push_back(cyc);
            obs_num.push_back(int'(bus_if.note_num));
            obs_idx.push_back(int'(bus_if.note_index));
            obs_on.push_back(0);
         end
         if (bus_if.note_on) begin
            if (obs_on.size() == 0) on_orphan = 1;
            else obs_on[obs_on.size()-1] = obs_on[obs_on.size()-1] + 1;
            if (prev_p) on_in_pause = 1;
         end
         prev_s = bus_if.note_strobe;
         if (bus_if.song_done) begin
            done_cyc = cyc;
            break;
         end
         bus_if.start = (cyc == poke);
         if (pmode == 1) bus_if.pause = ($urandom_range(0, 3) == 0);
         else if (pmode == 2) bus_if.pause = (cyc >= pf) && (cyc < pf + pl);
         else bus_if.pause = 1'b0;
         prev_p = bus_if.pause;
      end
      bus_if.pause = 1'b0;
      bus_if.start = 1'b0;
      timeout = (done_cyc < 0);
   endtask

   task automatic test_reset();
      n_checks++; if (bus_if.note_num !== 8'h00) begin n_errors++; $display("FAIL reset_note_num: got %0h expected 0", bus_if.note_num); end
      n_checks++; if (bus_if.note_on !== 1'b0) begin n_errors++; $display("FAIL reset_note_on: got %b expected 0", bus_if.note_on); end
      n_checks++; if (bus_if.note_strobe !== 1'b0) begin n_errors++; $display("FAIL reset_strobe: got %b expected 0", bus_if.note_strobe); end
      n_checks++; if (bus_if.note_index !== 5'd0) begin n_errors++; $display("FAIL reset_index: got %0d expected 0", bus_if.note_index); end
      n_checks++; if (bus_if.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", bus_if.busy); end
      n_checks++; if (bus_if.song_done !== 1'b0) begin n_errors++; $display("FAIL reset_song_done: got %b expected 0", bus_if.song_done); end
   endtask

   task automatic test_start_ignored();
      bit seen;
      seen = 0;
      bus_if.notes_valid = 1'b0;
      @(negedge clk); bus_if.start = 1'b1;
      @(negedge clk); bus_if.start = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (bus_if.busy || bus_if.note_strobe || bus_if.song_done) seen = 1;
      end
      n_checks++; if (seen) begin n_errors++; $display("FAIL start_without_valid: got activity 1 expected 0"); end
      bus_if.notes_valid = 1'b1;
   endtask

   task automatic test_songs();
      int nk;
      for (int s = 0; s < 9; s++) begin
         for (int i = 0; i < 32; i++) tbl[i] = 16'h0000;
         case (s)
            0: tbl[0] = 16'h3C02;
            1: begin tbl[0] = 16'h0003; tbl[1] = 16'h4001; end
            2: for (int i = 0; i < 32; i++) tbl[i] = 16'h4101;
            5: rand_table(32);
            default: rand_table($urandom_range(1, 8));
         endcase
         load_table();
         build_expected();
         run_song(exp_done + 20, 0, (s >= 3) ? 3 : 0);
         n_checks++; if (timeout) begin n_errors++; $display("FAIL song%0d_timeout: got no song_done, expected at cycle %0d", s, exp_done); end
         n_checks++; if (obs_cyc.size() != exp_cyc.size()) begin n_errors++; $display("FAIL song%0d_strobe_count: got %0d expected %0d", s, obs_cyc.size(), exp_cyc.size()); end
         nk = (obs_cyc.size() < exp_cyc.size()) ? obs_cyc.size() : exp_cyc.size();
         for (int k = 0; k < nk; k++) begin
            n_checks++; if (obs_cyc[k] != exp_cyc[k]) begin n_errors++; $display("FAIL song%0d_strobe%0d_cycle: got %0d expected %0d", s, k, obs_cyc[k], exp_cyc[k]); end
            n_checks++; if (obs_num[k] != exp_num[k]) begin n_errors++; $display("FAIL song%0d_strobe%0d_num: got %0h expected %0h", s, k, obs_num[k], exp_num[k]); end
            n_checks++; if (obs_idx[k] != exp_idx[k]) begin n_errors++; $display("FAIL song%0d_strobe%0d_index: got %0d expected %0d", s, k, obs_idx[k], exp_idx[k]); end
            n_checks++; if (obs_on[k] != exp_on[k]) begin n_errors++; $display("FAIL song%0d_note%0d_on_time: got %0d expected %0d", s, k, obs_on[k], exp_on[k]); end
         end
         n_checks++; if (done_cyc != exp_done) begin n_errors++; $display("FAIL song%0d_done_cycle: got %0d expected %0d", s, done_cyc, exp_done); end
         n_checks++; if (dbl_strobe || on_orphan) begin n_errors++; $display("FAIL song%0d_strobe_shape: got double=%0d orphan_on=%0d expected 0 0", s, dbl_strobe, on_orphan); end
         if (s == 0) begin
            n_checks++;
            if (obs_cyc.size() < 1 || obs_cyc[0] != 2 || obs_num[0] != 8'h3C || obs_on[0] != 8) begin
               n_errors++; $display("FAIL song0_first_note: got %0d strobes, expected strobe at 2 num 3c on 8 cycles", obs_cyc.size());
            end
         end
      end
   endtask

   task automatic test_pause();
      int nk;
      for (int i = 0; i < 32; i++) tbl[i] = 16'h0000;
      tbl[0] = 16'h3C04;
      load_table();
      pf = 3; pl = 7;
      run_song(80, 2, 0);
      n_checks++; if (timeout || done_cyc != 26) begin n_errors++; $display("FAIL pause_window_done: got %0d expected 26", done_cyc); end
      n_checks++; if (obs_on.size() != 1 || obs_on[0] != 16) begin n_errors++; $display("FAIL pause_window_on_time: got %0d notes, expected one of 16 cycles", obs_on.size()); end
      n_checks++; if (on_in_pause) begin n_errors++; $display("FAIL pause_window_silence: got note_on during pause, expected 0"); end

      rand_table(5);
      load_table();
      build_expected();
      run_song(4 * exp_done + 40, 1, 0);
      n_checks++; if (timeout) begin n_errors++; $display("FAIL pause_rand_timeout: got no song_done, expected completion"); end
      n_checks++; if (obs_cyc.size() != exp_cyc.size()) begin n_errors++; $display("FAIL pause_rand_strobe_count: got %0d expected %0d", obs_cyc.size(), exp_cyc.size()); end
      nk = (obs_cyc.size() < exp_cyc.size()) ? obs_cyc.size() : exp_cyc.size();
      for (int k = 0; k < nk; k++) begin
         n_checks++; if (obs_num[k] != exp_num[k] || obs_idx[k] != exp_idx[k]) begin n_errors++; $display("FAIL pause_rand_note%0d_word: got %0h@%0d expected %0h@%0d", k, obs_num[k], obs_idx[k], exp_num[k], exp_idx[k]); end
         n_checks++; if (obs_on[k] != exp_on[k]) begin n_errors++; $display("FAIL pause_rand_note%0d_on_time: got %0d expected %0d", k, obs_on[k], exp_on[k]); end
      end
      n_checks++; if (on_in_pause || dbl_strobe) begin n_errors++; $display("FAIL pause_rand_shape: got on_in_pause=%0d double=%0d expected 0 0", on_in_pause, dbl_strobe); end
   endtask

   task automatic test_abort();
      bit seen;
      for (int i = 0; i < 32; i++) tbl[i] = 16'h0000;
      tbl[0] = 16'h3C04;
      load_table();
      @(negedge clk); bus_if.start = 1'b1;
      @(negedge clk); bus_if.start = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++; if (bus_if.note_on !== 1'b1) begin n_errors++; $display("FAIL abort_pre_note_on: got %b expected 1", bus_if.note_on); end
      bus_if.notes_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (bus_if.note_on !== 1'b0) begin n_errors++; $display("FAIL abort_note_on: got %b expected 0", bus_if.note_on); end
      n_checks++; if (bus_if.busy !== 1'b0 || bus_if.song_done !== 1'b0) begin n_errors++; $display("FAIL abort_state: got busy=%b done=%b expected 0 0", bus_if.busy, bus_if.song_done); end
      seen = bus_if.note_strobe;
      repeat (4) begin
         @(negedge clk);
         if (bus_if.note_strobe || bus_if.busy || bus_if.note_on) seen = 1;
      end
      n_checks++; if (seen) begin n_errors++; $display("FAIL abort_stays_idle: got activity 1 expected 0"); end
      bus_if.notes_valid = 1'b1;
   endtask

   task automatic test_reset_mid_play();
      for (int i = 0; i < 32; i++) tbl[i] = 16'h0000;
      tbl[0] = 16'h3C02; tbl[1] = 16'h4101;
      load_table();
      build_expected();
      @(negedge clk); bus_if.start = 1'b1;
      @(negedge clk); bus_if.start = 1'b0;
      repeat (4) @(negedge clk);
      n_checks++; if (bus_if.busy !== 1'b1 || bus_if.note_on !== 1'b1) begin n_errors++; $display("FAIL midreset_pre: got busy=%b on=%b expected 1 1", bus_if.busy, bus_if.note_on); end
      #2 reset = 1'b0;
      #1;
      n_checks++; if (bus_if.note_on !== 1'b0) begin n_errors++; $display("FAIL midreset_note_on: got %b expected 0", bus_if.note_on); end
      n_checks++; if ({bus_if.note_num, bus_if.note_index, bus_if.busy, bus_if.song_done, bus_if.note_strobe} !== 16'h0000) begin
         n_errors++; $display("FAIL midreset_outputs: got num=%0h idx=%0d busy=%b done=%b strobe=%b expected all 0", bus_if.note_num, bus_if.note_index, bus_if.busy, bus_if.song_done, bus_if.note_strobe);
      end
      @(negedge clk); reset = 1'b1;
      run_song(exp_done + 20, 0, 0);
      n_checks++; if (obs_idx.size() < 1 || obs_idx[0] != 0 || obs_num[0] != 8'h3C || obs_cyc[0] != 2) begin n_errors++; $display("FAIL midreset_replay_first: got %0d strobes, expected index 0 num 3c at cycle 2", obs_idx.size()); end
      n_checks++; if (obs_cyc.size() != exp_cyc.size() || done_cyc != exp_done) begin n_errors++; $display("FAIL midreset_replay_done: got %0d expected %0d", done_cyc, exp_done); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got time limit, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0;
      bus_if.notes_valid = 1'b1;
      bus_if.start = 1'b0;
      bus_if.pause = 1'b0;
      for (int i = 0; i < 32; i++) bus_if.notes[i] = 16'h0000;
      repeat (3) @(negedge clk);
      test_reset();
      reset = 1'b1;
      @(negedge clk);
      test_start_ignored();
      test_songs();
      test_pause();
      test_abort();
      test_reset_mid_play();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
